// File: rtl/fp8_issue_ctrl_pkg.sv
// Shared encodings for the FP8 issue controller: op codes, special values, FSM states.
package fp8_issue_ctrl_pkg;

    localparam logic [1:0] FP_ADDITION   = 2'b00;
    localparam logic [7:0] FP8_NAN       = 8'h7F;
    localparam logic [7:0] FP8_PLUS_INF  = 8'h78;
    localparam logic [7:0] FP8_MINUS_INF = 8'hF8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StBusy  = 2'd2,
        StDone  = 2'd3
    } issue_state_e;

    function automatic logic is_inf(input logic [7:0] v);
        return (v == FP8_PLUS_INF) || (v == FP8_MINUS_INF);
    endfunction

endpackage

// File: rtl/fp8_special_resolve.sv
// Combinational special-value result for an addition flagged by the exception checker.
module fp8_special_resolve
    import fp8_issue_ctrl_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] result_o,
    output logic       nan_o
);

    always_comb begin
        result_o = FP8_NAN;
        if (a_i == FP8_NAN || b_i == FP8_NAN) begin
            result_o = FP8_NAN;
        end else if (is_inf(a_i) && is_inf(b_i) && (a_i != b_i)) begin
            result_o = FP8_NAN;
        end else if (is_inf(a_i)) begin
            result_o = a_i;
        end else if (is_inf(b_i)) begin
            result_o = b_i;
        end
        nan_o = (result_o == FP8_NAN);
    end

endmodule

// File: rtl/fp8_issue_ctrl.sv
// Issue/sequencing stage for the 8-bit FPU: handshake in, exception check, core launch, result out.
// Optional busy watchdog enabled by defining FP8_TIMEOUT_EN.
module fp8_issue_ctrl
    import fp8_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [1:0] IN_OP,
    input  logic [7:0] IN_A,
    input  logic [7:0] IN_B,
    output logic [1:0] EXC_FP_OPERATION,
    output logic [7:0] EXC_OP_A,
    output logic [7:0] EXC_OP_B,
    input  logic       EXC_IS_EXCEPTION,
    output logic       CORE_START,
    output logic [1:0] CORE_OP,
    output logic [7:0] CORE_A,
    output logic [7:0] CORE_B,
    input  logic       CORE_DONE,
    input  logic [7:0] CORE_RESULT,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] OUT_RESULT,
    output logic [2:0] OUT_FLAGS
);

    issue_state_e state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [7:0]   a_q, a_d, b_q, b_d;
    logic         core_start_q, core_start_d;
    logic         out_valid_q, out_valid_d;
    logic [7:0]   out_result_q, out_result_d;
    logic [2:0]   out_flags_q, out_flags_d;
    logic [7:0]   spec_result;
    logic         spec_nan;

`ifdef FP8_TIMEOUT_EN
    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
    logic [15:0] busy_cnt_q, busy_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    fp8_special_resolve u_special_resolve (
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (spec_result),
        .nan_o    (spec_nan)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        core_start_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
`ifdef FP8_TIMEOUT_EN
        busy_cnt_d   = busy_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    op_d    = IN_OP;
                    a_d     = IN_A;
                    b_d     = IN_B;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (EXC_IS_EXCEPTION) begin
                    out_result_d = spec_result;
                    out_flags_d  = {1'b0, spec_nan, 1'b1};
                    out_valid_d  = 1'b1;
                    state_d      = StDone;
                end else begin
                    core_start_d = 1'b1;
                    state_d      = StBusy;
`ifdef FP8_TIMEOUT_EN
                    busy_cnt_d   = '0;
`endif
                end
            end
            StBusy: begin
`ifdef FP8_TIMEOUT_EN
                busy_cnt_d = busy_cnt_q + 16'd1;
`endif
                // A core result arriving on the limit cycle takes priority over the watchdog.
                if (CORE_DONE) begin
                    out_result_d = CORE_RESULT;
                    out_flags_d  = {1'b0, CORE_RESULT == FP8_NAN, 1'b0};
                    out_valid_d  = 1'b1;
                    state_d      = StDone;
                end
`ifdef FP8_TIMEOUT_EN
                else if (busy_cnt_d == TimeoutLimit) begin
                    out_result_d = FP8_NAN;
                    out_flags_d  = 3'b110;
                    out_valid_d  = 1'b1;
                    state_d      = StDone;
                end
`endif
            end
            StDone: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
`ifdef FP8_TIMEOUT_EN
            busy_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            core_start_q <= core_start_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
`ifdef FP8_TIMEOUT_EN
            busy_cnt_q   <= busy_cnt_d;
`endif
        end
    end

    assign IN_READY         = (state_q == StIdle);
    assign EXC_FP_OPERATION = op_q;
    assign EXC_OP_A         = a_q;
    assign EXC_OP_B         = b_q;
    assign CORE_OP          = op_q;
    assign CORE_A           = a_q;
    assign CORE_B           = b_q;
    assign CORE_START       = core_start_q;
    assign OUT_VALID        = out_valid_q;
    assign OUT_RESULT       = out_result_q;
    assign OUT_FLAGS        = out_flags_q;

endmodule

// File: tb/tb_fp8_issue_ctrl.sv
// Directed self-checking bench for fp8_issue_ctrl with a simple exception checker and core model.
module tb_fp8_issue_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [1:0] IN_OP = 2'b00;
    logic [7:0] IN_A = 8'h00;
    logic [7:0] IN_B = 8'h00;
    logic [1:0] EXC_FP_OPERATION;
    logic [7:0] EXC_OP_A, EXC_OP_B;
    logic       EXC_IS_EXCEPTION;
    logic       CORE_START;
    logic [1:0] CORE_OP;
    logic [7:0] CORE_A, CORE_B;
    logic       CORE_DONE = 1'b0;
    logic [7:0] CORE_RESULT;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [7:0] OUT_RESULT;
    logic [2:0] OUT_FLAGS;

    int n_tests = 0;
    int n_fail  = 0;

    // Core model: DONE pulses three cycles after the START cycle when enabled.
    logic       core_en  = 1'b1;
    logic [7:0] core_res = 8'h00;
    int         core_cnt = 0;
    int         start_cnt = 0;

    always #5 CLK = ~CLK;

    fp8_issue_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .IN_VALID         (IN_VALID),
        .IN_READY         (IN_READY),
        .IN_OP            (IN_OP),
        .IN_A             (IN_A),
        .IN_B             (IN_B),
        .EXC_FP_OPERATION (EXC_FP_OPERATION),
        .EXC_OP_A         (EXC_OP_A),
        .EXC_OP_B         (EXC_OP_B),
        .EXC_IS_EXCEPTION (EXC_IS_EXCEPTION),
        .CORE_START       (CORE_START),
        .CORE_OP          (CORE_OP),
        .CORE_A           (CORE_A),
        .CORE_B           (CORE_B),
        .CORE_DONE        (CORE_DONE),
        .CORE_RESULT      (CORE_RESULT),
        .OUT_VALID        (OUT_VALID),
        .OUT_READY        (OUT_READY),
        .OUT_RESULT       (OUT_RESULT),
        .OUT_FLAGS        (OUT_FLAGS)
    );

    function automatic logic is_special(input logic [7:0] v);
        return (v == 8'h7F) || (v == 8'h78) || (v == 8'hF8);
    endfunction

    assign EXC_IS_EXCEPTION = is_special(EXC_OP_A) || is_special(EXC_OP_B);
    assign CORE_RESULT      = core_res;

    always @(posedge CLK) begin
        CORE_DONE <= 1'b0;
        if (CORE_START) start_cnt <= start_cnt + 1;
        if (CORE_START && core_en) begin
            core_cnt <= 2;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) CORE_DONE <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        IN_VALID = 1'b1;
        IN_OP    = 2'b00;
        IN_A     = a;
        IN_B     = b;
        tick();
        IN_VALID = 1'b0;
    endtask

    // Counts edges after the accept edge until OUT_VALID is seen; bounded.
    task automatic wait_valid(input string tag, output int cycles);
        cycles = 0;
        while (!OUT_VALID && cycles < 30) begin
            tick();
            cycles++;
        end
        if (!OUT_VALID) check_eq({tag, "_valid_timeout"}, 32'(OUT_VALID), 32'd1);
    endtask

    task automatic drain(input string tag);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check_eq({tag, "_valid_clr"}, 32'(OUT_VALID), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
    endtask

    initial begin
        int lat;
        int s0;

        tick();
        tick();
        RST = 1'b0;
        check_eq("rst_in_ready", 32'(IN_READY), 32'd1);
        check_eq("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check_eq("rst_core_start", 32'(CORE_START), 32'd0);
        check_eq("rst_out_result", 32'(OUT_RESULT), 32'h00);
        check_eq("rst_out_flags", 32'(OUT_FLAGS), 32'd0);
        check_eq("rst_exc_a", 32'(EXC_OP_A), 32'h00);

        // 1: normal add through the core
        core_res = 8'h40;
        s0 = start_cnt;
        issue(8'h38, 8'h38);
        check_eq("t1_in_ready_low", 32'(IN_READY), 32'd0);
        check_eq("t1_start_in_check", 32'(CORE_START), 32'd0);
        tick();
        check_eq("t1_start_pulse", 32'(CORE_START), 32'd1);
        check_eq("t1_core_a", 32'(CORE_A), 32'h38);
        wait_valid("t1", lat);
        // Accept edge +1 to BUSY, +3 core, +1 to register the result.
        check_eq("t1_latency", 32'(lat + 1), 32'd5);
        check_eq("t1_result", 32'(OUT_RESULT), 32'h40);
        check_eq("t1_flags", 32'(OUT_FLAGS), 32'b000);
        check_eq("t1_start_count", 32'(start_cnt - s0), 32'd1);
        drain("t1");

        // Core path returning NaN raises only the NaN flag.
        core_res = 8'h7F;
        issue(8'h40, 8'h38);
        wait_valid("t1n", lat);
        check_eq("t1n_result", 32'(OUT_RESULT), 32'h7F);
        check_eq("t1n_flags", 32'(OUT_FLAGS), 32'b010);
        drain("t1n");

        // 2: special path, +inf + finite
        s0 = start_cnt;
        issue(8'h78, 8'h38);
        check_eq("t2_valid_early", 32'(OUT_VALID), 32'd0);
        wait_valid("t2", lat);
        check_eq("t2_latency", 32'(lat), 32'd1);
        check_eq("t2_result", 32'(OUT_RESULT), 32'h78);
        check_eq("t2_flags", 32'(OUT_FLAGS), 32'b001);
        check_eq("t2_no_start", 32'(start_cnt - s0), 32'd0);
        drain("t2");

        // 3: inf - inf and NaN operand; also finite + -inf
        issue(8'h78, 8'hF8);
        wait_valid("t3a", lat);
        check_eq("t3a_result", 32'(OUT_RESULT), 32'h7F);
        check_eq("t3a_flags", 32'(OUT_FLAGS), 32'b011);
        drain("t3a");
        issue(8'h7F, 8'h38);
        wait_valid("t3b", lat);
        check_eq("t3b_result", 32'(OUT_RESULT), 32'h7F);
        check_eq("t3b_flags", 32'(OUT_FLAGS), 32'b011);
        drain("t3b");
        issue(8'h10, 8'hF8);
        wait_valid("t3c", lat);
        check_eq("t3c_result", 32'(OUT_RESULT), 32'hF8);
        check_eq("t3c_flags", 32'(OUT_FLAGS), 32'b001);
        drain("t3c");

        // 4: back-pressure in DONE keeps outputs stable
        issue(8'hF8, 8'h7F);
        wait_valid("t4", lat);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_hold_valid", 32'(OUT_VALID), 32'd1);
            check_eq("t4_hold_result", 32'(OUT_RESULT), 32'h7F);
            check_eq("t4_hold_flags", 32'(OUT_FLAGS), 32'b011);
            check_eq("t4_hold_in_ready", 32'(IN_READY), 32'd0);
            tick();
        end
        drain("t4");

        // 5: reset while BUSY; the stale CORE_DONE that follows must be ignored
        core_res = 8'h40;
        issue(8'h38, 8'h38);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_out_valid", 32'(OUT_VALID), 32'd0);
            check_eq("t5_in_ready", 32'(IN_READY), 32'd1);
            tick();
        end
        check_eq("t5_out_result", 32'(OUT_RESULT), 32'h00);
        check_eq("t5_out_flags", 32'(OUT_FLAGS), 32'd0);
        check_eq("t5_core_start", 32'(CORE_START), 32'd0);
        check_eq("t5_exc_a", 32'(EXC_OP_A), 32'h00);

`ifdef FP8_TIMEOUT_EN
        // 6: core never answers; watchdog fires after four BUSY cycles
        core_en = 1'b0;
        issue(8'h38, 8'h40);
        wait_valid("t6", lat);
        check_eq("t6_latency", 32'(lat), 32'd5);
        check_eq("t6_result", 32'(OUT_RESULT), 32'h7F);
        check_eq("t6_flags", 32'(OUT_FLAGS), 32'b110);
        drain("t6");
        core_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
